panel_scan_controller: RTL

Sequencer that drives one `panel_driver` instance. It generates `shift`, `load_led_vals`, `load_brightness`, `pwm_time` and `active_row_addr` so that every row of the frame RAMs is scanned through all PWM steps. It blanks the row drivers during each row change and inserts brightness-load sequences on request. It sits between the frame-buffer writer, which uses `frame_start` as its frame sync, and the panel datapath.

---
 rtl/panel_scan_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/panel_scan_controller.sv
// panel_scan_controller: scan sequencer that drives a panel_driver through every PWM step of every row.
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   enable                 scanning runs while high; a started row always completes
//   brightness_update      1-cycle request, serviced at the next row boundary or from idle
//   shift                  serial shift strobe (LED values or brightness word)
//   load_led_vals          latch strobe for LED values
//   load_brightness        latch strobe for brightness
//   pwm_time               current PWM compare step
//   active_row_addr        RAM read row / row select
//   blank                  row drivers must be off
//   row_done, frame_start  1-cycle pulses on the last blank cycle of a row change
module panel_scan_controller #(
  parameter int SHIFT_BITS   = 16,
  parameter int PWM_BITS     = 8,
  parameter int ROW_BITS     = 4,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                brightness_update,
  output logic                shift,
  output logic                load_led_vals,
  output logic                load_brightness,
  output logic [PWM_BITS-1:0] pwm_time,
  output logic [ROW_BITS-1:0] active_row_addr,
  output logic                blank,
  output logic                row_done,
  output logic                frame_start
);
  localparam int BW = $clog2(SHIFT_BITS + 1);
  localparam int LW = $clog2(BLANK_CYCLES);
  localparam logic [BW-1:0] BMAX = BW'(SHIFT_BITS - 1);
  localparam logic [LW-1:0] LMAX = LW'(BLANK_CYCLES - 1);
  localparam logic [LW-1:0] LPRE = LW'(BLANK_CYCLES - 2);
  localparam logic [PWM_BITS-1:0] PMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_BLANK, S_BR_SHIFT, S_BR_LATCH} state_t;

  state_t state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [LW-1:0] bcnt_q, bcnt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic pend_q, pend_d;
  logic done_d, fs_d;
  logic shift_q, led_q, bri_q, blank_q, done_q, fs_q;

  always_comb begin
    state_d = state_q;
    pwm_d = pwm_q;
    row_d = row_q;
    done_d = 1'b0;
    fs_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = enable ? (pend_q ? S_BR_SHIFT : S_SHIFT) : S_IDLE;
      S_SHIFT: state_d = bit_q == BMAX ? S_LATCH : S_SHIFT;
      S_LATCH: begin
        // pwm_time wraps to 0 by overflow on the last step, which is also the row change
        state_d = pwm_q == PMAX ? S_BLANK : S_SHIFT;
        pwm_d = pwm_q + 1'b1;
        row_d = pwm_q == PMAX ? row_q + 1'b1 : row_q;
      end
      S_BLANK: begin
        // pulses are registered, so they are armed one cycle before the last blank cycle
        done_d = bcnt_q == LPRE;
        fs_d = bcnt_q == LPRE && row_q == '0;
        state_d = bcnt_q != LMAX ? S_BLANK : pend_q ? S_BR_SHIFT : enable ? S_SHIFT : S_IDLE;
      end
      S_BR_SHIFT: state_d = bit_q == BMAX ? S_BR_LATCH : S_BR_SHIFT;
      S_BR_LATCH: state_d = enable ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    bit_d = ((state_q == S_SHIFT || state_q == S_BR_SHIFT) && state_d == state_q) ? bit_q + 1'b1 : '0;
    bcnt_d = (state_q == S_BLANK && state_d == S_BLANK) ? bcnt_q + 1'b1 : '0;
    // a request arriving in the same cycle as the clear survives
    pend_d = brightness_update | (pend_q & ~(state_d == S_BR_SHIFT && state_q != S_BR_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bit_q <= '0;
      bcnt_q <= '0;
      pwm_q <= '0;
      row_q <= '0;
      pend_q <= 1'b0;
      shift_q <= 1'b0;
      led_q <= 1'b0;
      bri_q <= 1'b0;
      blank_q <= 1'b0;
      done_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      bcnt_q <= bcnt_d;
      pwm_q <= pwm_d;
      row_q <= row_d;
      pend_q <= pend_d;
      shift_q <= state_d == S_SHIFT || state_d == S_BR_SHIFT;
      led_q <= state_d == S_LATCH;
      bri_q <= state_d == S_BR_LATCH;
      blank_q <= state_d == S_IDLE || state_d == S_BLANK || state_d == S_BR_SHIFT || state_d == S_BR_LATCH;
      done_q <= done_d;
      fs_q <= fs_d;
    end
  end

  assign shift = shift_q;
  assign load_led_vals = led_q;
  assign load_brightness = bri_q;
  assign pwm_time = pwm_q;
  assign active_row_addr = row_q;
  assign blank = blank_q;
  assign row_done = done_q;
  assign frame_start = fs_q;
endmodule
